// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, ALU codes,
// FSM states and the instruction classes the decoder works in.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_ADDI, C_ORI, C_LW, C_SW, C_J, C_ILL
  } iclass_t;

  function automatic iclass_t classify(input logic [5:0] op);
    case (op)
      OP_RTYPE: return C_R;
      OP_ADDI:  return C_ADDI;
      OP_ORI:   return C_ORI;
      OP_LW:    return C_LW;
      OP_SW:    return C_SW;
      OP_J:     return C_J;
      default:  return C_ILL;
    endcase
  endfunction

endpackage

// File: rtl/imm_extend.sv
// Widens the 16-bit instruction immediate to the datapath width,
// either sign- or zero-extended.
module imm_extend #(
  parameter int DATA_W = 32
) (
  input  logic [15:0]       imm16,
  input  logic              zero_ext,
  output logic [DATA_W-1:0] imm_ext
);

  generate
    if (DATA_W > 16) begin : g_wide
      logic [DATA_W-17:0] upper;
      assign upper   = zero_ext ? '0 : {(DATA_W-16){imm16[15]}};
      assign imm_ext = {upper, imm16};
    end else begin : g_narrow
      logic unused_mode;
      assign unused_mode = zero_ext;
      assign imm_ext     = imm16;
    end
  endgenerate

endmodule

// File: rtl/multicycle_control_unit.sv
// Sequencer for the multi-cycle CPU: fetch over req/ack, decode from the IR,
// step EXEC/MEM/WB with one-cycle strobes and an ack timeout on both buses.
module multicycle_control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic [31:0]           instr_in,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [DATA_W-1:0]     imm,
  output logic [15:0]           jump_offset,
  output logic [2:0]            alu_func,
  output logic                  alu_src_imm,
  output logic                  pc_en,
  output logic                  pc_sel,
  output logic                  reg_we,
  output logic                  reg_wsel,
  output logic                  wb_from_mem,
  output logic                  illegal,
  output logic                  bus_err,
  output logic [2:0]            state_o
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_reg;
  logic [31:0] ir_reg;
  logic [7:0]  cnt_reg;
  logic        imem_req_reg, dmem_req_reg, dmem_we_reg, alu_src_imm_reg;
  logic        pc_en_reg, pc_sel_reg, reg_we_reg, wb_from_mem_reg;
  logic        illegal_reg, bus_err_reg;

  iclass_t ir_class;
  iclass_t fetch_class;

  assign ir_class    = classify(ir_reg[31:26]);
  assign fetch_class = classify(instr_in[31:26]);

  // Decoded fields come straight off the IR, so they hold until the next fetch lands.
  assign rs          = ir_reg[21 +: REG_ADDR_W];
  assign rt          = ir_reg[16 +: REG_ADDR_W];
  assign rd          = ir_reg[11 +: REG_ADDR_W];
  assign jump_offset = ir_reg[15:0];
  assign reg_wsel    = (ir_class == C_ADDI) || (ir_class == C_ORI) ||
                       (ir_class == C_LW)   || (ir_class == C_SW);

  always_comb begin
    alu_func = ALU_ADD;
    case (ir_class)
      C_R:     alu_func = ir_reg[2:0];
      C_ORI:   alu_func = ALU_OR;
      default: alu_func = ALU_ADD;
    endcase
  end

  imm_extend #(.DATA_W(DATA_W)) u_imm_extend (
    .imm16    (ir_reg[15:0]),
    .zero_ext (ir_class == C_ORI),
    .imm_ext  (imm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_FETCH;
      ir_reg          <= '0;
      cnt_reg         <= '0;
      imem_req_reg    <= 1'b0;
      dmem_req_reg    <= 1'b0;
      dmem_we_reg     <= 1'b0;
      alu_src_imm_reg <= 1'b0;
      pc_en_reg       <= 1'b0;
      pc_sel_reg      <= 1'b0;
      reg_we_reg      <= 1'b0;
      wb_from_mem_reg <= 1'b0;
      illegal_reg     <= 1'b0;
      bus_err_reg     <= 1'b0;
    end else begin
      pc_en_reg       <= 1'b0;
      pc_sel_reg      <= 1'b0;
      reg_we_reg      <= 1'b0;
      wb_from_mem_reg <= 1'b0;
      illegal_reg     <= 1'b0;
      bus_err_reg     <= 1'b0;
      alu_src_imm_reg <= 1'b0;
      case (state_reg)
        S_FETCH: begin
          // Request is raised one cycle after reset or a bus error, then held.
          if (!imem_req_reg) begin
            imem_req_reg <= 1'b1;
            cnt_reg      <= '0;
          end else if (imem_ack) begin
            imem_req_reg <= 1'b0;
            ir_reg       <= instr_in;
            state_reg    <= S_DECODE;
            if (fetch_class == C_J) begin
              pc_en_reg  <= 1'b1;
              pc_sel_reg <= 1'b1;
            end else if (fetch_class == C_ILL) begin
              pc_en_reg   <= 1'b1;
              illegal_reg <= 1'b1;
            end
          end else if (cnt_reg == TIMEOUT_C) begin
            imem_req_reg <= 1'b0;
            bus_err_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        S_DECODE: begin
          if (ir_class == C_J || ir_class == C_ILL) begin
            state_reg    <= S_FETCH;
            imem_req_reg <= 1'b1;
            cnt_reg      <= '0;
          end else begin
            state_reg       <= S_EXEC;
            alu_src_imm_reg <= (ir_class != C_R);
          end
        end
        S_EXEC: begin
          if (ir_class == C_LW || ir_class == C_SW) begin
            state_reg    <= S_MEM;
            dmem_req_reg <= 1'b1;
            dmem_we_reg  <= (ir_class == C_SW);
            cnt_reg      <= '0;
          end else begin
            state_reg  <= S_WB;
            reg_we_reg <= 1'b1;
            pc_en_reg  <= 1'b1;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req_reg <= 1'b0;
            dmem_we_reg  <= 1'b0;
            pc_en_reg    <= 1'b1;
            if (ir_class == C_LW) begin
              state_reg       <= S_WB;
              reg_we_reg      <= 1'b1;
              wb_from_mem_reg <= 1'b1;
            end else begin
              state_reg    <= S_FETCH;
              imem_req_reg <= 1'b1;
              cnt_reg      <= '0;
            end
          end else if (cnt_reg == TIMEOUT_C) begin
            // Abandon the access; the PC is left alone so the same fetch is retried.
            dmem_req_reg <= 1'b0;
            dmem_we_reg  <= 1'b0;
            bus_err_reg  <= 1'b1;
            state_reg    <= S_FETCH;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        S_WB: begin
          state_reg    <= S_FETCH;
          imem_req_reg <= 1'b1;
          cnt_reg      <= '0;
        end
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign dmem_req    = dmem_req_reg;
  assign dmem_we     = dmem_we_reg;
  assign alu_src_imm = alu_src_imm_reg;
  assign pc_en       = pc_en_reg;
  assign pc_sel      = pc_sel_reg;
  assign reg_we      = reg_we_reg;
  assign wb_from_mem = wb_from_mem_reg;
  assign illegal     = illegal_reg;
  assign bus_err     = bus_err_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: the driver pushes the reference outcome of each instruction,
// a monitor summarises each completed instruction and compares it.
module tb_multicycle_control_unit;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int TIMEOUT    = 15;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [31:0]           instr_in;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0]     imm;
  logic [15:0]           jump_offset;
  logic [2:0]            alu_func, state_o;
  logic                  alu_src_imm, pc_en, pc_sel, reg_we, reg_wsel;
  logic                  wb_from_mem, illegal, bus_err;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack),
    .instr_in(instr_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .jump_offset(jump_offset), .alu_func(alu_func), .alu_src_imm(alu_src_imm),
    .pc_en(pc_en), .pc_sel(pc_sel), .reg_we(reg_we), .reg_wsel(reg_wsel),
    .wb_from_mem(wb_from_mem), .illegal(illegal), .bus_err(bus_err),
    .state_o(state_o)
  );

  // Summary of one instruction, from first fetch request to its closing strobe.
  typedef struct packed {
    logic        pc_en;
    logic        pc_sel;
    logic [1:0]  reg_we_n;
    logic        reg_wsel;
    logic [1:0]  wb_n;
    logic [1:0]  illegal_n;
    logic        bus_err;
    logic        dmem_we;
    logic        alu_src_imm;
    logic [7:0]  imem_cyc;
    logic [7:0]  dmem_cyc;
    logic [7:0]  lat;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [15:0] joff;
    logic [2:0]  alu_func;
  } txn_t;

  typedef struct packed {
    txn_t t;
    logic dec_chk;
    logic joff_chk;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn_no = 0;

  function automatic logic is_mem(input logic [31:0] ins);
    return ins[31:26] == 6'h23 || ins[31:26] == 6'h2B;
  endfunction

  // fd/md are ack delays in cycles; anything beyond TIMEOUT means the ack never comes.
  function automatic exp_t model(input logic [31:0] ins, input int fd, input int md);
    exp_t e;
    logic [5:0] op;
    e = '0;
    op = ins[31:26];
    if (fd > TIMEOUT) begin
      e.t.bus_err  = 1'b1;
      e.t.imem_cyc = 8'(TIMEOUT + 1);
      return e;
    end
    e.t.imem_cyc = 8'(fd + 1);
    e.t.rs       = ins[25:21];
    e.t.rt       = ins[20:16];
    e.t.rd       = ins[15:11];
    e.t.joff     = ins[15:0];
    e.joff_chk   = 1'b1;
    if (op == 6'h0D || !ins[15]) e.t.imm = 32'(ins[15:0]);
    else                         e.t.imm = 32'hFFFF_0000 + 32'(ins[15:0]);
    e.t.alu_func = (op == 6'h00) ? ins[2:0] : (op == 6'h0D) ? 3'd3 : 3'd0;
    e.t.reg_wsel = (op == 6'h08 || op == 6'h0D || op == 6'h23 || op == 6'h2B);
    if (op == 6'h02) begin
      e.t.pc_en  = 1'b1;
      e.t.pc_sel = 1'b1;
      e.t.lat    = 8'd1;
    end else if (!(op == 6'h00 || e.t.reg_wsel)) begin
      e.t.pc_en     = 1'b1;
      e.t.illegal_n = 2'd1;
      e.t.lat       = 8'd1;
    end else begin
      e.dec_chk       = 1'b1;
      e.t.alu_src_imm = (op != 6'h00);
      if (is_mem(ins)) begin
        e.t.dmem_we = (op == 6'h2B);
        if (md > TIMEOUT) begin
          e.t.bus_err  = 1'b1;
          e.t.dmem_cyc = 8'(TIMEOUT + 1);
          e.t.lat      = 8'(4 + TIMEOUT);
        end else begin
          e.t.pc_en    = 1'b1;
          e.t.dmem_cyc = 8'(md + 1);
          e.t.lat      = 8'(4 + md);
          if (op == 6'h23) begin
            e.t.reg_we_n = 2'd1;
            e.t.wb_n     = 2'd1;
          end
        end
      end else begin
        e.t.pc_en    = 1'b1;
        e.t.reg_we_n = 2'd1;
        e.t.lat      = 8'd3;
      end
    end
    return e;
  endfunction

  function automatic txn_t mask(input txn_t t, input logic dec_chk, input logic joff_chk);
    txn_t m;
    m = t;
    if (!dec_chk) begin
      m.rs = '0; m.rt = '0; m.rd = '0; m.imm = '0; m.alu_func = '0; m.reg_wsel = 1'b0;
    end
    if (!joff_chk) m.joff = '0;
    return m;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  // Monitor: accumulate per-instruction activity, close a record on pc_en or bus_err.
  initial begin
    txn_t acc;
    txn_t obs;
    exp_t e;
    logic ack_seen;
    acc = '0;
    ack_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc = '0;
        ack_seen = 1'b0;
        continue;
      end
      if (ack_seen) acc.lat = acc.lat + 8'd1;
      if (reg_we)      acc.reg_we_n  = acc.reg_we_n + 2'd1;
      if (wb_from_mem) acc.wb_n      = acc.wb_n + 2'd1;
      if (illegal)     acc.illegal_n = acc.illegal_n + 2'd1;
      if (alu_src_imm) acc.alu_src_imm = 1'b1;
      if (pc_en || bus_err) begin
        obs          = acc;
        obs.pc_en    = pc_en;
        obs.pc_sel   = pc_sel;
        obs.bus_err  = bus_err;
        obs.reg_wsel = reg_wsel;
        obs.rs       = 5'(rs);
        obs.rt       = 5'(rt);
        obs.rd       = 5'(rd);
        obs.imm      = 32'(imm);
        obs.joff     = jump_offset;
        obs.alu_func = alu_func;
        total++;
        txn_no++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL txn%0d: unexpected completion %h, nothing expected", txn_no, obs);
        end else begin
          e = exp_q.pop_front();
          if (mask(obs, e.dec_chk, e.joff_chk) !== mask(e.t, e.dec_chk, e.joff_chk)) begin
            bad++;
            $display("FAIL txn%0d: got %h want %h", txn_no,
                     mask(obs, e.dec_chk, e.joff_chk), mask(e.t, e.dec_chk, e.joff_chk));
          end else begin
            $display("txn%0d ok: pc_en=%0b bus_err=%0b lat=%0d imem=%0d dmem=%0d",
                     txn_no, obs.pc_en, obs.bus_err, obs.lat, obs.imem_cyc, obs.dmem_cyc);
          end
        end
        acc = '0;
        ack_seen = 1'b0;
      end
      if (imem_req) acc.imem_cyc = acc.imem_cyc + 8'd1;
      if (imem_req && imem_ack) begin
        ack_seen = 1'b1;
        acc.lat  = 8'd0;
      end
      if (dmem_req) begin
        acc.dmem_cyc = acc.dmem_cyc + 8'd1;
        if (dmem_we) acc.dmem_we = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] ins, input int d);
    int n;
    n = 0;
    while (!imem_req && n < 40) begin tick(); n++; end
    if (!imem_req) begin
      total++; bad++;
      $display("FAIL fetch_wait: imem_req=0 want 1");
      return;
    end
    if (d > TIMEOUT) begin
      repeat (TIMEOUT + 1) tick();
      return;
    end
    repeat (d) tick();
    instr_in = ins;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    instr_in = $urandom;
  endtask

  task automatic do_mem(input int d);
    int n;
    n = 0;
    while (!dmem_req && n < 10) begin tick(); n++; end
    if (!dmem_req) begin
      total++; bad++;
      $display("FAIL mem_wait: dmem_req=0 want 1");
      return;
    end
    if (d > TIMEOUT) begin
      repeat (TIMEOUT + 1) tick();
      return;
    end
    repeat (d) tick();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input int fd, input int md);
    exp_q.push_back(model(ins, fd, md));
    do_fetch(ins, fd);
    if (fd <= TIMEOUT && is_mem(ins)) do_mem(md);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  ill;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[31:26] = 6'h00;
      1: r[31:26] = 6'h08;
      2: r[31:26] = 6'h0D;
      3: r[31:26] = 6'h23;
      4: r[31:26] = 6'h2B;
      5: r[31:26] = 6'h02;
      default: begin
        ill = 6'($urandom_range(16, 63));
        if (ill == 6'h23 || ill == 6'h2B) ill = 6'h3F;
        r[31:26] = ill;
      end
    endcase
    return r;
  endfunction

  initial begin
    int n;
    int fd;
    int md;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    instr_in = '0;
    rst      = 1'b1;
    repeat (3) tick();
    check("reset_outputs",
          {imem_req, dmem_req, dmem_we, rs, rt, rd, imm, jump_offset, alu_func,
           alu_src_imm, pc_en, pc_sel, reg_we, reg_wsel, wb_from_mem, illegal,
           bus_err, state_o}, '0);
    rst = 1'b0;

    issue(32'h012A_4020, 2, 0);                          // R-type add
    issue({6'h08, 5'd3, 5'd4, 16'hFFFF}, 0, 0);          // ADDI, sign-extended
    issue({6'h0D, 5'd5, 5'd6, 16'hFFFF}, 1, 0);          // ORI, zero-extended
    issue({6'h23, 5'd7, 5'd8, 16'h0040}, 0, 5);          // LW, slow RAM
    issue({6'h2B, 5'd9, 5'd10, 16'h8004}, 0, 2);         // SW
    issue({6'h02, 10'd0, 16'h0010}, 0, 0);               // J
    issue({6'h3F, 26'h123_4567}, 0, 0);                  // illegal opcode
    issue({6'h2B, 5'd1, 5'd2, 16'h0008}, 0, TIMEOUT + 1); // RAM never acks
    issue({6'h23, 5'd1, 5'd2, 16'h0008}, 0, TIMEOUT);     // ack in last allowed cycle
    issue(32'h0, TIMEOUT + 1, 0);                         // fetch never acks
    issue(32'h0043_2825, TIMEOUT, 0);                     // fetch ack in last allowed cycle

    // Reset while a load is waiting on the RAM.
    do_fetch({6'h23, 5'd2, 5'd3, 16'h0004}, 0);
    n = 0;
    while (!dmem_req && n < 10) begin tick(); n++; end
    check("rst_mem_pre_dmem_req", {127'd0, dmem_req}, 128'd1);
    rst = 1'b1;
    tick();
    check("rst_mem_dmem_req", {127'd0, dmem_req}, '0);
    check("rst_mem_state", {125'd0, state_o}, '0);
    check("rst_mem_strobes", {125'd0, pc_en, reg_we, imem_req}, '0);
    rst = 1'b0;
    issue({6'h08, 5'd11, 5'd12, 16'h1234}, 0, 0);         // clean fetch after reset

    for (int i = 0; i < 50; i++) begin
      fd = ($urandom_range(0, 11) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 3));
      md = ($urandom_range(0, 11) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 6));
      issue(rand_instr(), fd, md);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    check("scoreboard_drained", 128'(exp_q.size()), '0);
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
